pio_in_edge_capture: RTL and testbench
======================================

# pio_in_edge_capture

Parametrised Avalon-MM slave input port, the next-generation general-purpose input PIO for the video system. It samples a WIDTH-bit external input bus through a synchroniser and an optional per-bit debouncer, exposes the level, latches selected edges into a write-1-to-clear capture register, and drives a maskable interrupt. It sits on the system interconnect beside the other PIO slaves and is read by the CPU as a 4-word register block.

## Interface

Parameters:

- WIDTH, 8, number of input bits (1..32); readdata bits above WIDTH-1 read 0
- SYNC_STAGES, 2, synchroniser flops per bit (>=2)
- DEBOUNCE_CYCLES, 0, consecutive stable cycles required before a level change is accepted; 0 disables the debouncer
- EDGE_TYPE, 0, edges captured: 0 rising, 1 falling, 2 any
- IRQ_MODE, 1, 0 level (irq from masked level), 1 edge (irq from masked capture)

Ports:

- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- address  in  2  word address of register
- chipselect  in  1  slave select; qualifies writes
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- in_port  in  WIDTH  asynchronous external inputs
- irq  out  1  interrupt request, active high

## Operation

- Register map: 0 DATA (RO, current accepted level); 1 reserved (reads 0, writes ignored); 2 IRQMASK (RW, WIDTH bits); 3 EDGECAP (read; write 1 clears that bit, write 0 leaves it).
- A write occurs when chipselect=1 and write_n=0. Writes to address 0/1 have no effect.
- readdata is loaded every cycle from the addressed register, independent of chipselect (one-cycle read latency), zero-extended to 32 bits.
- Synchroniser: SYNC_STAGES-deep flop chain per bit; output s.
- Debouncer (DEBOUNCE_CYCLES>0): per-bit register `level` and counter of width clog2(DEBOUNCE_CYCLES+1). s==level: counter<=0. s!=level: counter increments; when counter==DEBOUNCE_CYCLES-1, level<=s and counter<=0. A bounce back to the old value before the limit resets the counter. With DEBOUNCE_CYCLES=0, level=s.
- Edge detect: level_d registers level; rise=level&~level_d, fall=~level&level_d; the selected edge set by EDGE_TYPE sets the EDGECAP bit the next cycle.
- Set wins over clear: an edge on bit i in the same cycle as a write-1-clear of bit i leaves bit i set.
- irq = |(level & IRQMASK) for IRQ_MODE 0, |(EDGECAP & IRQMASK) for IRQ_MODE 1; combinational from registers, no glitch-producing inputs.

## Timing

- Reset: readdata=0, IRQMASK=0, EDGECAP=0, synchroniser chain=0, level=0, level_d=0, counters=0, irq=0. Reset is honoured mid-operation at any cycle and discards pending debounce counts.
- A high input after reset is seen as a rising edge (chain resets to 0); this is intended.
- Latency, DEBOUNCE_CYCLES=0: in_port change sampled at edge k; level valid after edge k+SYNC_STAGES-1; EDGECAP set after edge k+SYNC_STAGES; irq (edge mode) asserts in that same cycle; DATA in readdata after edge k+SYNC_STAGES.
- Debounce adds DEBOUNCE_CYCLES cycles to every path above.
- Pulses shorter than one clock may be missed; with debounce on, pulses shorter than DEBOUNCE_CYCLES are always rejected.
- Write to IRQMASK or EDGECAP takes effect on irq the cycle after the write edge; readback of the new value appears in readdata one cycle after that.

## Test plan

- Reset: reset_n low with in_port=0xFF, random bus activity -> readdata, irq, all registers 0 throughout; after release DATA reads 0xFF within SYNC_STAGES+1 cycles.
- Rising capture (WIDTH=8, EDGE_TYPE=0, IRQ_MODE=1, mask=0x01): in_port 0x00->0x01 -> EDGECAP=0x01, irq=1 exactly SYNC_STAGES+1 edges after sampling; write 0x01 to addr 3 -> irq=0 next cycle, EDGECAP reads 0.
- Set-vs-clear collision: time a write of 0xFF to addr 3 in the cycle bit 2 edge is detected -> EDGECAP=0x04 afterwards, other bits cleared.
- EDGE_TYPE=1 and 2: 0x0F->0xF0 -> EDGECAP 0x0F (falling) / 0xFF (any); mask=0x00 -> irq stays 0.
- Debounce (DEBOUNCE_CYCLES=4): bit 0 glitches high 3 cycles -> DATA, EDGECAP unchanged; held high 4 cycles -> DATA bit 0=1 after SYNC_STAGES+4 cycles, one capture only.
- Level mode (IRQ_MODE=0, mask=0x80): in_port bit7 high -> irq high while bit set, low SYNC_STAGES cycles after it drops; reads of addr 1 return 0; readdata[31:WIDTH]=0 always.

Source files
------------

// File: rtl/pio_in_edge_capture.sv
// pio_in_edge_capture
//
// Avalon-MM general-purpose input port. Each in_port bit passes through a
// synchroniser chain and an optional per-bit debouncer to become the
// accepted level. Selected edges of that level are latched into a
// write-1-to-clear capture register, which (or the level itself) is masked
// to form the interrupt.
//
// Register map (word addresses):
//   0 DATA     RO  accepted input level
//   1 reserved     reads 0, writes ignored
//   2 IRQMASK  RW  per-bit interrupt enable
//   3 EDGECAP  RW1C captured edges; a new edge wins over a same-cycle clear
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   address     register word address
//   chipselect  slave select, qualifies writes
//   write_n     active-low write strobe
//   writedata   write data (bits above WIDTH-1 ignored)
//   readdata    registered read data, one-cycle latency, zero-extended
//   in_port     asynchronous external inputs
//   irq         interrupt request, active high

module pio_in_edge_capture #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0,
    parameter int IRQ_MODE        = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CAP  = 2'd3;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_chain;
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] level_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_sel;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] cap_clear;
    logic             wr_en;
    logic [31:0]      read_mux;
    logic             unused_wdata;

    // Upper writedata bits are don't-care for narrow ports.
    assign unused_wdata = ^writedata;

    // ---------------------------------------------------------------
    // Synchroniser: stage 0 samples the raw pins.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_chain <= '0;
        end else begin
            sync_chain[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_chain[i] <= sync_chain[i-1];
            end
        end
    end

    assign sync_out = sync_chain[SYNC_STAGES-1];

    // ---------------------------------------------------------------
    // Debouncer: a new value must persist for DEBOUNCE_CYCLES consecutive
    // cycles before it becomes the accepted level. Any return to the
    // current level restarts the count.
    // ---------------------------------------------------------------
    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
            assign level = sync_out;
        end else begin : g_deb
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
                logic          lvl;
                logic [CW-1:0] cnt;

                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        lvl <= 1'b0;
                        cnt <= '0;
                    end else if (sync_out[gi] == lvl) begin
                        cnt <= '0;
                    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                        lvl <= sync_out[gi];
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                assign level[gi] = lvl;
            end
        end
    endgenerate

    // ---------------------------------------------------------------
    // Edge detection and capture
    // ---------------------------------------------------------------
    assign rise = level & ~level_d;
    assign fall = ~level & level_d;

    always_comb begin
        edge_sel = '0;
        case (EDGE_TYPE)
            0:       edge_sel = rise;
            1:       edge_sel = fall;
            default: edge_sel = rise | fall;
        endcase
    end

    assign wr_en     = chipselect & ~write_n;
    assign cap_clear = (wr_en && address == ADDR_CAP) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_d  <= '0;
            edge_cap <= '0;
            irq_mask <= '0;
        end else begin
            level_d  <= level;
            // OR-ing the new edges after the clear makes set win a collision.
            edge_cap <= (edge_cap & ~cap_clear) | edge_sel;
            if (wr_en && address == ADDR_MASK) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    // ---------------------------------------------------------------
    // Read path: loaded every cycle regardless of chipselect.
    // ---------------------------------------------------------------
    always_comb begin
        read_mux = '0;
        case (address)
            ADDR_DATA: read_mux = 32'(level);
            ADDR_RSVD: read_mux = '0;
            ADDR_MASK: read_mux = 32'(irq_mask);
            ADDR_CAP:  read_mux = 32'(edge_cap);
            default:   read_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= read_mux;
        end
    end

    // Interrupt is formed only from registered state, so it cannot glitch
    // on bus or pin activity.
    generate
        if (IRQ_MODE == 0) begin : g_irq_level
            assign irq = |(level & irq_mask);
        end else begin : g_irq_edge
            assign irq = |(edge_cap & irq_mask);
        end
    endgenerate

endmodule

// File: tb/tb_pio_in_edge_capture.sv
// Testbench for pio_in_edge_capture. Four instances share one bus and one
// input pin set, differing in edge type, irq mode and debounce length.
// A behavioural model (sample-history queue, run-length debounce, register
// image) predicts readdata and irq of every instance each cycle.

module tb_pio_in_edge_capture;

    localparam int W  = 8;
    localparam int SS = 3;
    localparam int ET [4] = '{0, 1, 2, 0};
    localparam int IM [4] = '{1, 1, 0, 1};
    localparam int DB [4] = '{0, 0, 0, 4};

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   rd [4];
    logic          irq_o [4];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dut
            pio_in_edge_capture #(
                .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB[gi]),
                .EDGE_TYPE(ET[gi]), .IRQ_MODE(IM[gi])
            ) u_dut (
                .clk(clk), .reset_n(reset_n), .address(address),
                .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
                .readdata(rd[gi]), .in_port(in_port), .irq(irq_o[gi])
            );
        end
    endgenerate

    // ---------------- reference model ----------------
    logic [7:0]  m_lvl  [4];
    logic [7:0]  m_lvd  [4];
    logic [7:0]  m_cap  [4];
    logic [7:0]  m_mask [4];
    logic [31:0] m_rd   [4];
    int          run    [4][8];
    logic [7:0]  hist   [$];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic m_irq(int k);
        if (IM[k] == 0) return |(m_lvl[k] & m_mask[k]);
        return |(m_cap[k] & m_mask[k]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_lvl[k] = 0; m_lvd[k] = 0; m_cap[k] = 0; m_mask[k] = 0; m_rd[k] = 0;
            for (int b = 0; b < 8; b++) run[k][b] = 0;
        end
        hist.delete();
        for (int i = 0; i < SS; i++) hist.push_back(8'h00);
    endtask

    // One clock edge: the model consumes the inputs present at the edge,
    // then outputs are sampled 1 time unit later.
    task automatic tick();
        logic [7:0] sb, sa, lb, sel, clr;
        logic       wr;
        @(posedge clk);
        if (!reset_n) begin
            #1;
            return;
        end
        wr = chipselect && !write_n;
        sb = hist[SS-1];
        hist.push_front(in_port);
        void'(hist.pop_back());
        sa = hist[SS-1];
        clr = (wr && address == 2'd3) ? writedata[7:0] : 8'h00;
        for (int k = 0; k < 4; k++) begin
            lb = m_lvl[k];
            case (ET[k])
                0:       sel = lb & ~m_lvd[k];
                1:       sel = ~lb & m_lvd[k];
                default: sel = lb ^ m_lvd[k];
            endcase
            case (address)
                2'd0:    m_rd[k] = {24'h0, lb};
                2'd2:    m_rd[k] = {24'h0, m_mask[k]};
                2'd3:    m_rd[k] = {24'h0, m_cap[k]};
                default: m_rd[k] = 32'h0;
            endcase
            m_cap[k] = (m_cap[k] & ~clr) | sel;
            if (wr && address == 2'd2) m_mask[k] = writedata[7:0];
            m_lvd[k] = lb;
            if (DB[k] == 0) begin
                m_lvl[k] = sa;
            end else begin
                for (int b = 0; b < 8; b++) begin
                    if (sb[b] != lb[b]) begin
                        run[k][b]++;
                        if (run[k][b] == DB[k]) begin
                            m_lvl[k][b] = sb[b];
                            run[k][b] = 0;
                        end
                    end else begin
                        run[k][b] = 0;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic settle(int n);
        repeat (n) tick();
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        in_port = 8'hFF;
        #2 reset_n = 1'b0;
        model_reset();
        for (int c = 0; c < 8; c++) begin
            address = 2'($urandom); chipselect = 1'($urandom);
            write_n = 1'($urandom); writedata = $urandom;
            tick();
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (rd[k] !== 32'h0) begin
                    n_bad++; $display("FAIL reset_rd dut%0d: got %h want 0", k, rd[k]);
                end
                n_cmp++;
                if (irq_o[k] !== 1'b0) begin
                    n_bad++; $display("FAIL reset_irq dut%0d: got %b want 0", k, irq_o[k]);
                end
            end
        end
        reset_n = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        for (int t = 1; t <= SS + 1; t++) begin
            tick();
            n_cmp++;
            if (rd[0] !== m_rd[0]) begin
                n_bad++; $display("FAIL release_rd t%0d: got %h want %h", t, rd[0], m_rd[0]);
            end
        end
        n_cmp++;
        if (rd[0] !== 32'hFF) begin
            n_bad++; $display("FAIL release_data: got %h want 000000ff", rd[0]);
        end
        $display("test_reset done: compared=%0d mismatched=%0d", n_cmp, n_bad);
    endtask

    task automatic test_rising();
        logic exp_irq;
        in_port = 8'h00;
        settle(14);
        wr(2'd2, 32'h01);
        wr(2'd3, 32'hFF);
        tick();
        in_port = 8'h01;
        for (int t = 1; t <= SS + 3; t++) begin
            tick();
            exp_irq = (t >= SS + 1);
            n_cmp++;
            if (irq_o[0] !== exp_irq) begin
                n_bad++; $display("FAIL rise_irq t%0d: got %b want %b", t, irq_o[0], exp_irq);
            end
            if (t == SS + 2) begin
                n_cmp++;
                if (rd[0] !== 32'h01) begin
                    n_bad++; $display("FAIL rise_cap: got %h want 00000001", rd[0]);
                end
            end
        end
        wr(2'd3, 32'h01);
        n_cmp++;
        if (irq_o[0] !== 1'b0) begin
            n_bad++; $display("FAIL clear_irq: got %b want 0", irq_o[0]);
        end
        tick();
        n_cmp++;
        if (rd[0] !== 32'h0) begin
            n_bad++; $display("FAIL clear_cap: got %h want 0", rd[0]);
        end
        $display("test_rising done: compared=%0d mismatched=%0d", n_cmp, n_bad);
    endtask

    task automatic test_collision();
        in_port = 8'h09;
        settle(14);
        in_port = 8'h0D;
        repeat (SS) tick();
        wr(2'd3, 32'hFF);
        tick();
        n_cmp++;
        if (rd[0] !== 32'h04) begin
            n_bad++; $display("FAIL collision_cap: got %h want 00000004", rd[0]);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (rd[k] !== m_rd[k]) begin
                n_bad++; $display("FAIL collision_model dut%0d: got %h want %h", k, rd[k], m_rd[k]);
            end
        end
        $display("test_collision done: compared=%0d mismatched=%0d", n_cmp, n_bad);
    endtask

    task automatic test_edge_types();
        logic [31:0] exp [4];
        exp = '{32'hF0, 32'h0F, 32'hFF, 32'hF0};
        wr(2'd2, 32'h00);
        in_port = 8'h0F;
        settle(14);
        wr(2'd3, 32'hFF);
        tick();
        in_port = 8'hF0;
        for (int t = 0; t < 14; t++) begin
            tick();
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (irq_o[k] !== 1'b0) begin
                    n_bad++; $display("FAIL edge_irq dut%0d t%0d: got %b want 0", k, t, irq_o[k]);
                end
            end
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (rd[k] !== exp[k]) begin
                n_bad++; $display("FAIL edge_cap dut%0d: got %h want %h", k, rd[k], exp[k]);
            end
        end
        $display("test_edge_types done: compared=%0d mismatched=%0d", n_cmp, n_bad);
    endtask

    task automatic test_debounce();
        in_port = 8'h00;
        settle(14);
        wr(2'd2, 32'h01);
        wr(2'd3, 32'hFF);
        address = 2'd0;
        tick();
        in_port = 8'h01;
        repeat (3) tick();
        in_port = 8'h00;
        for (int t = 0; t < 12; t++) begin
            tick();
            n_cmp++;
            if (rd[3] !== 32'h0 || irq_o[3] !== 1'b0) begin
                n_bad++; $display("FAIL glitch dut3 t%0d: data=%h irq=%b want 0/0", t, rd[3], irq_o[3]);
            end
        end
        address = 2'd3;
        tick();
        n_cmp++;
        if (rd[3] !== 32'h0) begin
            n_bad++; $display("FAIL glitch_cap: got %h want 0", rd[3]);
        end
        address = 2'd0;
        in_port = 8'h01;
        for (int t = 1; t <= SS + 5; t++) begin
            tick();
            if (t == SS + 4) begin
                n_cmp++;
                if (rd[3] !== 32'h0 || irq_o[3] !== 1'b0) begin
                    n_bad++; $display("FAIL deb_early: data=%h irq=%b want 0/0", rd[3], irq_o[3]);
                end
            end
            if (t == SS + 5) begin
                n_cmp++;
                if (rd[3] !== 32'h1 || irq_o[3] !== 1'b1) begin
                    n_bad++; $display("FAIL deb_accept: data=%h irq=%b want 1/1", rd[3], irq_o[3]);
                end
            end
        end
        settle(10);
        wr(2'd3, 32'h01);
        for (int t = 0; t < 8; t++) begin
            tick();
            n_cmp++;
            if (rd[3] !== 32'h0) begin
                n_bad++; $display("FAIL deb_once t%0d: cap=%h want 0", t, rd[3]);
            end
        end
        $display("test_debounce done: compared=%0d mismatched=%0d", n_cmp, n_bad);
    endtask

    task automatic test_level_mode();
        in_port = 8'h00;
        settle(14);
        wr(2'd2, 32'h80);
        address = 2'd1;
        tick();
        in_port = 8'h80;
        for (int t = 1; t <= SS + 5; t++) begin
            tick();
            n_cmp++;
            if (irq_o[2] !== (t >= SS)) begin
                n_bad++; $display("FAIL lvl_rise t%0d: irq=%b want %b", t, irq_o[2], (t >= SS));
            end
            n_cmp++;
            if (rd[2] !== 32'h0) begin
                n_bad++; $display("FAIL rsvd_read t%0d: got %h want 0", t, rd[2]);
            end
        end
        in_port = 8'h00;
        for (int t = 1; t <= SS + 1; t++) begin
            tick();
            n_cmp++;
            if (irq_o[2] !== (t < SS)) begin
                n_bad++; $display("FAIL lvl_fall t%0d: irq=%b want %b", t, irq_o[2], (t < SS));
            end
        end
        $display("test_level_mode done: compared=%0d mismatched=%0d", n_cmp, n_bad);
    endtask

    task automatic test_reset_mid();
        in_port = 8'h00;
        settle(14);
        in_port = 8'h01;
        settle(SS + 2);
        reset_n = 1'b0;
        #1;
        model_reset();
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (rd[k] !== 32'h0 || irq_o[k] !== 1'b0) begin
                    n_bad++; $display("FAIL midreset dut%0d: rd=%h irq=%b want 0/0", k, rd[k], irq_o[k]);
                end
            end
            tick();
        end
        reset_n = 1'b1;
        in_port = 8'h00;
        address = 2'd0;
        for (int t = 0; t < 12; t++) begin
            tick();
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (rd[k] !== m_rd[k]) begin
                    n_bad++; $display("FAIL after_midreset dut%0d: got %h want %h", k, rd[k], m_rd[k]);
                end
            end
        end
        $display("test_reset_mid done: compared=%0d mismatched=%0d", n_cmp, n_bad);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 5) == 0) in_port = 8'($urandom);
            else if ($urandom_range(0, 7) == 0) in_port ^= 8'(1 << $urandom_range(0, 7));
            address    = 2'($urandom);
            chipselect = 1'($urandom);
            write_n    = ($urandom_range(0, 3) != 0);
            writedata  = $urandom;
            tick();
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (rd[k] !== m_rd[k]) begin
                    n_bad++; $display("FAIL rand_rd dut%0d c%0d: got %h want %h", k, c, rd[k], m_rd[k]);
                end
                n_cmp++;
                if (irq_o[k] !== m_irq(k)) begin
                    n_bad++; $display("FAIL rand_irq dut%0d c%0d: got %b want %b", k, c, irq_o[k], m_irq(k));
                end
                n_cmp++;
                if (rd[k][31:8] !== 24'h0) begin
                    n_bad++; $display("FAIL rand_upper dut%0d c%0d: got %h want 0", k, c, rd[k][31:8]);
                end
            end
        end
        chipselect = 1'b0; write_n = 1'b1;
        $display("test_random done: compared=%0d mismatched=%0d", n_cmp, n_bad);
    endtask

    initial begin
        reset_n = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'h0; in_port = 8'h00;
        model_reset();
        test_reset();
        test_rising();
        test_collision();
        test_edge_types();
        test_debounce();
        test_level_mode();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
